dm_byte: RTL and testbench
==========================

DM_BYTE -- requirements
Module: dm_byte

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width; depth = 2**ADDR_W 32-bit words.
REQ-002 Parameter CLEAR_ON_RESET, default 1, enables the post-reset zero-fill sweep (0 = no sweep; busy never asserts).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 addr  input  ADDR_W+2  byte address; [ADDR_W+1:2] word index, [1:0] byte offset.
REQ-006 data_in  input  32  store data, right-justified for byte/half stores.
REQ-007 MemWrite  input  1  store request, sampled on rising edge.
REQ-008 MemRead  input  1  load request, sampled on rising edge.
REQ-009 mem_op  input  3  access size/sign: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; 101-111 illegal.
REQ-010 data_out  output  32  registered load result.
REQ-011 busy  output  1  high while reset asserted or zero-fill sweep in progress.
REQ-012 misaligned  output  1  registered one-cycle error flag for rejected accesses.

Function
REQ-013 FSM states CLEAR and IDLE; reset forces CLEAR with sweep index 0 (CLEAR_ON_RESET=1), else IDLE.
REQ-014 CLEAR: writes 0 to word[index] each cycle, index+1; after writing word DEPTH-1 moves to IDLE; busy falls the cycle after the last word write (sweep = DEPTH cycles).
REQ-015 While busy=1, MemWrite/MemRead ignored; data_out and misaligned held at 0.
REQ-016 Store, mem_op 000: writes data_in to all 4 byte lanes of word[addr[ADDR_W+1:2]].
REQ-017 Store, mem_op 001/010: writes data_in[15:0] to lanes {1,0} if addr[1]=0, else lanes {3,2}; other lanes unchanged.
REQ-018 Store, mem_op 011/100: writes data_in[7:0] to lane addr[1:0]; other lanes unchanged.
REQ-019 Load: data_out updates on the rising edge that samples MemRead=1 (one-cycle latency); holds its value while MemRead=0.
REQ-020 Load word returns full word; half/byte returns the selected lane(s) (same lane rules as stores), sign-extended (001, 011) or zero-extended (010, 100) to 32 bits.
REQ-021 Simultaneous MemRead and MemWrite to same word: data_out returns pre-write contents (read-before-write); write still performed.
REQ-022 Misaligned = word with addr[1:0]!=0, or half with addr[0]=1; also any illegal mem_op.
REQ-023 Rejected access: no memory write; a load sets data_out to 0; misaligned=1 for exactly the following cycle, else 0.
REQ-024 Address wrap: word index is taken modulo depth; no out-of-range condition exists.

Reset
REQ-025 reset low: data_out=0, misaligned=0, busy=1, FSM to CLEAR (or IDLE if CLEAR_ON_RESET=0, busy=0), immediately and asynchronously.
REQ-026 Reset asserted mid-sweep restarts the sweep from index 0 after deassertion.
REQ-027 Memory array contents are not reset directly; zeroing comes only from the sweep.

Structure
REQ-028 Package dm_pkg holds the mem_op encodings, FSM state type, and lane-count constant (4).
REQ-029 Sub-module dm_load_ext (combinational) performs lane selection and sign/zero extension; dm_byte holds the array, store lane enables, FSM and output registers.

Verification
REQ-030 ADDR_W=4, reset pulse -> busy high for exactly 16 cycles after deassertion; word loads of indices 0 and 15 then return 0x00000000.
REQ-031 sw 0x12345678 @0x08; lb @0x0B -> 0x00000012; lh @0x0A -> 0x00001234; lbu @0x08 -> 0x00000078.
REQ-032 sw 0x0000FF80 @0x10; lb @0x10 -> 0xFFFFFF80; lbu @0x10 -> 0x00000080; lh @0x10 -> 0xFFFFFF80; lhu @0x10 -> 0x0000FF80.
REQ-033 sw 0xAABBCCDD @0x04; sb 0x11 @0x05, then sh 0x2233 @0x06; lw @0x04 -> 0x223311DD.
REQ-034 sw @0x02 with data 0xFFFFFFFF -> misaligned pulses 1 cycle, word @0x00 unchanged; lh @0x01 -> data_out 0, misaligned pulse; mem_op 111 -> same.
REQ-035 Same-edge lw+sw 0x5 @0x0C (prior 0x9) -> data_out 0x00000009, next lw -> 0x00000005; reset asserted mid-sweep at index 7 -> sweep restarts, busy lasts full 16 cycles.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the byte-addressable data memory: access encodings,
// FSM states and lane helpers used by the array and the load extender.
package dm_pkg;

  localparam int LANES = 4;

  localparam logic [2:0] OP_W  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_HU = 3'b010;
  localparam logic [2:0] OP_B  = 3'b011;
  localparam logic [2:0] OP_BU = 3'b100;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_e;

  // Illegal encodings count as rejected accesses alongside misalignment.
  function automatic logic op_bad(input logic [2:0] op, input logic [1:0] off);
    case (op)
      OP_W:        op_bad = (off != 2'b00);
      OP_H, OP_HU: op_bad = off[0];
      OP_B, OP_BU: op_bad = 1'b0;
      default:     op_bad = 1'b1;
    endcase
  endfunction

  function automatic logic [LANES-1:0] store_lanes(input logic [2:0] op, input logic [1:0] off);
    case (op)
      OP_W:        store_lanes = 4'b1111;
      OP_H, OP_HU: store_lanes = off[1] ? 4'b1100 : 4'b0011;
      OP_B, OP_BU: store_lanes = 4'b0001 << off;
      default:     store_lanes = 4'b0000;
    endcase
  endfunction

  // Replicate narrow store data so every candidate lane sees the right bytes.
  function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] din);
    case (op)
      OP_H, OP_HU: store_data = {2{din[15:0]}};
      OP_B, OP_BU: store_data = {4{din[7:0]}};
      default:     store_data = din;
    endcase
  endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Combinational load formatter: picks the addressed half/byte out of a word
// and sign- or zero-extends it to 32 bits.
module dm_load_ext
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  op,
  output logic [31:0] result
);

  logic [15:0] half_v;
  logic [7:0]  byte_v;

  always_comb begin
    half_v = off[1] ? word[31:16] : word[15:0];
    case (off)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
  end

  always_comb begin
    case (op)
      OP_W:    result = word;
      OP_H:    result = {{16{half_v[15]}}, half_v};
      OP_HU:   result = {16'h0000, half_v};
      OP_B:    result = {{24{byte_v[7]}}, byte_v};
      OP_BU:   result = {24'h000000, byte_v};
      default: result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dm_byte.sv
// Byte-addressable 32-bit data memory with sized/signed loads and stores,
// misalignment rejection and an optional post-reset zero-fill sweep.
module dm_byte
  import dm_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W+1:0] addr,
  input  logic [31:0]       data_in,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [2:0]        mem_op,
  output logic [31:0]       data_out,
  output logic              busy,
  output logic              misaligned
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [LANES-1:0][7:0] mem [DEPTH];

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     idx_q, idx_d;
  logic [ADDR_W-1:0]     word_idx;
  logic [1:0]            off;
  logic                  bad;
  logic [LANES-1:0]      wr_en;
  logic [ADDR_W-1:0]     wr_idx;
  logic [LANES-1:0][7:0] wr_data;
  logic [31:0]           rd_word;
  logic [31:0]           ld_val;

  assign word_idx = addr[ADDR_W+1:2];
  assign off      = addr[1:0];
  assign bad      = op_bad(mem_op, off);
  assign busy     = (state_q == CLEAR);
  assign rd_word  = mem[word_idx];

  dm_load_ext u_ext (
    .word   (rd_word),
    .off    (off),
    .op     (mem_op),
    .result (ld_val)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_en   = '0;
    wr_idx  = word_idx;
    wr_data = store_data(mem_op, data_in);
    case (state_q)
      CLEAR: begin
        wr_en   = '1;
        wr_idx  = idx_q;
        wr_data = '0;
        idx_d   = idx_q + 1'b1;
        if (&idx_q) state_d = IDLE;
      end
      default: begin
        if (MemWrite && !bad) wr_en = store_lanes(mem_op, off);
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CLEAR_ON_RESET ? CLEAR : IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Array is not reset; contents are zeroed only by the CLEAR sweep.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (wr_en[l]) mem[wr_idx][l] <= wr_data[l];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out   <= '0;
      misaligned <= 1'b0;
    end else if (state_q == CLEAR) begin
      data_out   <= '0;
      misaligned <= 1'b0;
    end else begin
      misaligned <= (MemRead || MemWrite) && bad;
      // Read-before-write: rd_word is the array value ahead of this edge's store.
      if (MemRead) data_out <= bad ? 32'h0000_0000 : ld_val;
    end
  end

endmodule

// File: tb/tb_dm_byte.sv
// Directed bench for dm_byte (ADDR_W=4): sweep timing, sized loads/stores,
// rejected accesses, read-before-write and mid-sweep reset.
module tb_dm_byte;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW+1:0] addr = '0;
  logic [31:0]   data_in = '0;
  logic          MemWrite = 1'b0;
  logic          MemRead = 1'b0;
  logic [2:0]    mem_op = 3'b000;
  logic [31:0]   data_out;
  logic          busy;
  logic          misaligned;

  int checks = 0;
  int errors = 0;

  dm_byte #(.ADDR_W(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .data_in    (data_in),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .mem_op     (mem_op),
    .data_out   (data_out),
    .busy       (busy),
    .misaligned (misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // One access: drive on the falling edge, sample 1 ns after the rising edge.
  task automatic access(input logic we, input logic re, input logic [2:0] op,
                        input logic [AW+1:0] a, input logic [31:0] d);
    @(negedge clk);
    MemWrite = we; MemRead = re; mem_op = op; addr = a; data_in = d;
    @(posedge clk);
    #1;
    MemWrite = 1'b0; MemRead = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    MemWrite = 1'b0; MemRead = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Counts cycles until busy falls, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int n;
    logic leak;

    #3;
    chk("rst_busy", {31'b0, busy}, 32'h1);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_misaligned", {31'b0, misaligned}, 32'h0);

    @(negedge clk);
    reset = 1'b1;
    count_busy(n);
    chk("sweep_len", n, 32'd16);

    access(0, 1, 3'b000, 6'h00, 0); chk("lw_idx0", data_out, 32'h0);
    access(0, 1, 3'b000, 6'h3C, 0); chk("lw_idx15", data_out, 32'h0);

    access(1, 0, 3'b000, 6'h08, 32'h12345678);
    access(0, 1, 3'b011, 6'h0B, 0); chk("lb_0B", data_out, 32'h00000012);
    access(0, 1, 3'b001, 6'h0A, 0); chk("lh_0A", data_out, 32'h00001234);
    access(0, 1, 3'b100, 6'h08, 0); chk("lbu_08", data_out, 32'h00000078);
    idle_cycle();                    chk("hold_no_read", data_out, 32'h00000078);

    access(1, 0, 3'b000, 6'h10, 32'h0000FF80);
    access(0, 1, 3'b011, 6'h10, 0); chk("lb_10", data_out, 32'hFFFFFF80);
    access(0, 1, 3'b100, 6'h10, 0); chk("lbu_10", data_out, 32'h00000080);
    access(0, 1, 3'b001, 6'h10, 0); chk("lh_10", data_out, 32'hFFFFFF80);
    access(0, 1, 3'b010, 6'h10, 0); chk("lhu_10", data_out, 32'h0000FF80);

    access(1, 0, 3'b000, 6'h04, 32'hAABBCCDD);
    access(1, 0, 3'b011, 6'h05, 32'h00000011);
    access(1, 0, 3'b001, 6'h06, 32'h00002233);
    access(0, 1, 3'b000, 6'h04, 0); chk("lw_04_merge", data_out, 32'h223311DD);
    chk("aligned_no_flag", {31'b0, misaligned}, 32'h0);

    access(1, 0, 3'b000, 6'h02, 32'hFFFFFFFF);
    chk("sw_mis_flag", {31'b0, misaligned}, 32'h1);
    idle_cycle();
    chk("sw_mis_one_cycle", {31'b0, misaligned}, 32'h0);
    access(0, 1, 3'b000, 6'h00, 0); chk("lw_00_unchanged", data_out, 32'h0);

    access(0, 1, 3'b000, 6'h08, 0); chk("lw_08", data_out, 32'h12345678);
    access(0, 1, 3'b001, 6'h01, 0); chk("lh_01_data", data_out, 32'h0);
    chk("lh_01_flag", {31'b0, misaligned}, 32'h1);

    access(0, 1, 3'b000, 6'h08, 0);
    access(0, 1, 3'b111, 6'h08, 0); chk("op111_ld_data", data_out, 32'h0);
    chk("op111_ld_flag", {31'b0, misaligned}, 32'h1);
    access(1, 0, 3'b111, 6'h08, 32'hFFFFFFFF);
    chk("op111_st_flag", {31'b0, misaligned}, 32'h1);
    access(0, 1, 3'b000, 6'h08, 0); chk("op111_no_write", data_out, 32'h12345678);
    chk("op111_flag_clear", {31'b0, misaligned}, 32'h0);

    access(1, 0, 3'b000, 6'h0C, 32'h9);
    access(1, 1, 3'b000, 6'h0C, 32'h5); chk("rbw_old", data_out, 32'h00000009);
    access(0, 1, 3'b000, 6'h0C, 0);     chk("rbw_new", data_out, 32'h00000005);

    // Mid-sweep reset, with a store/load held high that must be ignored while busy.
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_async_data", data_out, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", {31'b0, busy}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    MemWrite = 1'b1; MemRead = 1'b1; mem_op = 3'b000; addr = 6'h00; data_in = 32'hDEADBEEF;
    n = 0;
    leak = 1'b0;
    while (busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (busy && (data_out !== 32'h0 || misaligned !== 1'b0)) leak = 1'b1;
    end
    MemWrite = 1'b0; MemRead = 1'b0;
    chk("restart_len", n, 32'd16);
    chk("busy_outputs_zero", {31'b0, leak}, 32'h0);
    access(0, 1, 3'b000, 6'h00, 0); chk("busy_write_ignored", data_out, 32'h0);
    access(0, 1, 3'b000, 6'h08, 0); chk("resweep_08", data_out, 32'h0);
    access(0, 1, 3'b000, 6'h3C, 0); chk("resweep_15", data_out, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
